// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC[HIST_BITS+1:2] XOR global history indexes a table of
// saturating counters. Lookup is combinational; training and history advance only at resolve.
module gshare_predictor #(
  parameter int PC_WIDTH  = 64,
  parameter int HIST_BITS = 8,
  parameter int CTR_BITS  = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [PC_WIDTH-1:0]  lookup_pc,
  output logic                 lookup_taken,
  input  logic                 upd_valid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic                 upd_pred_taken,
  input  logic                 upd_mispredict,
  output logic [HIST_BITS-1:0] ghr_out,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispred
);

  localparam int ENTRIES = 1 << HIST_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;

  // The table must be readable in the same cycle it is addressed, so it lives in flops.
  logic [CTR_BITS-1:0]  pht_reg [ENTRIES];
  logic [HIST_BITS-1:0] ghr_reg;
  logic [31:0]          branches_reg;
  logic [31:0]          mispred_reg;

  logic [HIST_BITS-1:0] lookup_idx;
  logic [HIST_BITS-1:0] upd_idx;
  logic                 upd_actual;
  logic [CTR_BITS-1:0]  upd_ctr;
  logic [CTR_BITS-1:0]  ctr_next;

  assign lookup_idx = lookup_pc[HIST_BITS+1:2] ^ ghr_reg;
  assign upd_idx    = upd_pc[HIST_BITS+1:2] ^ ghr_reg;
  assign upd_actual = upd_pred_taken ^ upd_mispredict;
  assign upd_ctr    = pht_reg[upd_idx];

  always_comb begin
    ctr_next = upd_ctr;
    if (upd_actual && upd_ctr != CTR_MAX) begin
      ctr_next = upd_ctr + CTR_BITS'(1);
    end else if (!upd_actual && upd_ctr != CTR_MIN) begin
      ctr_next = upd_ctr - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_reg[i] <= CTR_INIT;
      end
      ghr_reg      <= '0;
      branches_reg <= '0;
      mispred_reg  <= '0;
    end else if (upd_valid) begin
      pht_reg[upd_idx] <= ctr_next;
      ghr_reg          <= {ghr_reg[HIST_BITS-2:0], upd_actual};
      branches_reg     <= branches_reg + 32'd1;
      mispred_reg      <= mispred_reg + {31'd0, upd_mispredict};
    end
  end

  assign lookup_taken  = pht_reg[lookup_idx][CTR_BITS-1];
  assign ghr_out       = ghr_reg;
  assign stat_branches = branches_reg;
  assign stat_mispred  = mispred_reg;

  // Bits outside the index window (alignment bits and upper PC) do not affect prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:HIST_BITS+2], lookup_pc[1:0],
                            upd_pc[PC_WIDTH-1:HIST_BITS+2], upd_pc[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed scenarios plus random traffic against a table model.
module tb_gshare_predictor;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [63:0] lookup_pc = '0;
  logic        lookup_taken;
  logic        upd_valid = 1'b0;
  logic [63:0] upd_pc = '0;
  logic        upd_pred_taken = 1'b0;
  logic        upd_mispredict = 1'b0;
  logic [7:0]  ghr_out;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  gshare_predictor #(.PC_WIDTH(64), .HIST_BITS(8), .CTR_BITS(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_pred_taken(upd_pred_taken),
    .upd_mispredict(upd_mispredict), .ghr_out(ghr_out),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: counters held as plain integers 0..3, history as an integer 0..255.
  int          m_pht [256];
  int          m_ghr;
  int unsigned m_branches;
  int unsigned m_mispred;

  int errors = 0;
  int checks = 0;
  logic        last_taken;
  logic [7:0]  last_ghr;

  function automatic int m_idx(input logic [63:0] pc);
    return int'((pc / 64'd4) % 64'd256) ^ m_ghr;
  endfunction

  function automatic bit m_predict(input logic [63:0] pc);
    return m_pht[m_idx(pc)] >= 2;
  endfunction

  // A PC (with junk in the ignored bits) that maps to table entry 'target' under the current history.
  function automatic logic [63:0] pc_for(input int target);
    return 64'hABCD_0000_0000_0000 + 64'((target ^ m_ghr) * 4) + 64'd3;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_branches = 0;
    m_mispred = 0;
  endtask

  task automatic m_update(input logic [63:0] pc, input bit pred, input bit mis);
    int  i;
    bit  actual;
    actual = pred ^ mis;
    i = m_idx(pc);
    if (actual) m_pht[i] = (m_pht[i] == 3) ? 3 : m_pht[i] + 1;
    else        m_pht[i] = (m_pht[i] == 0) ? 0 : m_pht[i] - 1;
    m_ghr = ((m_ghr * 2) + int'(actual)) % 256;
    m_branches = m_branches + 1;
    m_mispred = m_mispred + int'(mis);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check pre-edge outputs against the model, then advance the model.
  task automatic cycle(input bit rst, input bit v, input logic [63:0] pc, input bit pred,
                       input bit mis, input logic [63:0] lpc, input string tag);
    @(negedge clk_in);
    rst_in = rst;
    upd_valid = v;
    upd_pc = pc;
    upd_pred_taken = pred;
    upd_mispredict = mis;
    lookup_pc = lpc;
    #1;
    chk({tag, ".lookup"}, {63'd0, lookup_taken}, {63'd0, m_predict(lpc)});
    chk({tag, ".ghr"}, {56'd0, ghr_out}, 64'(m_ghr));
    chk({tag, ".branches"}, {32'd0, stat_branches}, 64'(m_branches));
    chk({tag, ".mispred"}, {32'd0, stat_mispred}, 64'(m_mispred));
    last_taken = lookup_taken;
    last_ghr = ghr_out;
    $display("%s: rst=%0d v=%0d pc=%h pred=%0d mis=%0d lpc=%h taken=%0d ghr=%h br=%0d mp=%0d",
             tag, rst, v, pc, pred, mis, lpc, lookup_taken, ghr_out, stat_branches, stat_mispred);
    @(posedge clk_in);
    if (rst) m_reset();
    else if (v) m_update(pc, pred, mis);
  endtask

  initial begin
    int          tgt;
    int          mis_first;
    int          mis_second;
    bit          p;
    bit          act;
    logic [63:0] pc;
    logic [63:0] pcs [8];

    m_reset();
    // Initial reset: outputs are unknown before it, so drive without checking.
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    // 1. Reset state
    cycle(0, 0, 64'd0, 0, 0, 64'h40_0000, "t1_reset");
    chk("t1_const_taken", {63'd0, last_taken}, 64'd0);
    chk("t1_const_ghr", {56'd0, last_ghr}, 64'd0);

    // 2. First mispredicted taken branch trains entry 0
    cycle(0, 1, 64'h1000, 0, 1, 64'h40_0000, "t2_update");
    cycle(0, 0, 64'd0, 0, 0, 64'h1000, "t2_look1000");
    chk("t2_const_1000", {63'd0, last_taken}, 64'd0);
    chk("t2_const_ghr", {56'd0, last_ghr}, 64'd1);
    chk("t2_const_mp", {32'd0, stat_mispred}, 64'd1);
    cycle(0, 0, 64'd0, 0, 0, 64'h1004, "t2_look1004");
    chk("t2_const_1004", {63'd0, last_taken}, 64'd1);

    // 3. Saturation on entry 0x55
    tgt = 8'h55;
    for (int k = 0; k < 5; k++) begin
      pc = pc_for(tgt);
      cycle(0, 1, pc, 0, 1, pc, "t3_taken");
    end
    cycle(0, 0, 64'd0, 0, 0, pc_for(tgt), "t3_sat_hi");
    chk("t3_const_sat_hi", {63'd0, last_taken}, 64'd1);
    pc = pc_for(tgt);
    cycle(0, 1, pc, 1, 1, pc, "t3_nt1");
    cycle(0, 0, 64'd0, 0, 0, pc_for(tgt), "t3_after_nt1");
    chk("t3_const_nt1", {63'd0, last_taken}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      pc = pc_for(tgt);
      cycle(0, 1, pc, 0, 0, pc, "t3_nt");
    end
    // One taken from a floor-saturated counter must still predict not-taken.
    pc = pc_for(tgt);
    cycle(0, 1, pc, 0, 1, pc, "t3_from_floor");
    cycle(0, 0, 64'd0, 0, 0, pc_for(tgt), "t3_after_floor");
    chk("t3_const_floor", {63'd0, last_taken}, 64'd0);

    // 4. Same-cycle lookup and update on one entry: old value now, new value next cycle
    tgt = 8'h3C;
    pc = pc_for(tgt);
    cycle(0, 1, pc, 0, 1, pc, "t4_same1");
    chk("t4_const_old", {63'd0, last_taken}, 64'd0);
    pc = pc_for(tgt);
    cycle(0, 1, pc, 0, 1, pc, "t4_same2");
    chk("t4_const_new", {63'd0, last_taken}, 64'd1);

    // 5. Reset wins over a concurrent update and discards all training
    cycle(1, 1, 64'h1004, 0, 1, 64'h1004, "t5_rst_upd");
    cycle(0, 0, 64'd0, 0, 0, 64'h1004, "t5_after");
    chk("t5_const_ghr", {56'd0, last_ghr}, 64'd0);
    chk("t5_const_br", {32'd0, stat_branches}, 64'd0);
    cycle(0, 0, 64'd0, 0, 0, 64'hABCD_0000_0000_0000 + 64'h55 * 4, "t5_old55");
    chk("t5_const_old55", {63'd0, last_taken}, 64'd0);

    // 6. Alternating loop branch at 0x2000
    mis_first = 0;
    mis_second = 0;
    for (int k = 0; k < 20; k++) begin
      p = m_predict(64'h2000);
      act = (k % 2 == 0);
      if (k < 10) mis_first += int'(p ^ act);
      else        mis_second += int'(p ^ act);
      cycle(0, 1, 64'h2000, p, p ^ act, 64'h2000, "t6_loop");
    end
    cycle(0, 0, 64'd0, 0, 0, 64'h2000, "t6_done");
    chk("t6_const_br", {32'd0, stat_branches}, 64'd20);
    chk("t6_const_mp", {32'd0, stat_mispred}, 64'(mis_first + mis_second));
    chk("t6_trend", 64'(mis_second <= mis_first), 64'd1);

    // 7. Random traffic over a small PC working set
    for (int k = 0; k < 8; k++) pcs[k] = {$urandom, $urandom};
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            pcs[$urandom_range(0, 7)], 1'($urandom), 1'($urandom),
            pcs[$urandom_range(0, 7)], "t7_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
